// File: rtl/tm1638_pkg.sv
// Shared TM1638 command bytes, sequencer state encoding and key-scan helpers.
package tm1638_pkg;

   localparam logic [7:0] CMD_KEY_READ   = 8'h42;
   localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
   localparam logic [7:0] CMD_ADDR_0     = 8'hC0;
   localparam logic [7:0] CMD_DISP_ON    = 8'h88;

   localparam int N_KEY_BYTES  = 4;
   localparam int N_DATA_BYTES = 16;

   typedef enum logic [3:0] {
      IDLE,
      KEY_CMD,
      KEY_RD,
      WR_CMD,
      ADDR_CMD,
      DATA,
      DISP_CMD,
      GAP,
      FRAME_END
   } tm_state_e;

   typedef enum logic [1:0] {
      PH_ISSUE,
      PH_WAIT_HI,
      PH_WAIT_LO
   } byte_phase_e;

   // Scan byte i carries one key on bit 0 and one on bit 4.
   function automatic logic [7:0] key_merge(input logic [7:0] acc,
                                            input logic [1:0] idx,
                                            input logic [7:0] rd);
      logic [7:0] r;
      r = acc;
      case (idx)
         2'd0: begin r[7] = rd[0]; r[3] = rd[4]; end
         2'd1: begin r[6] = rd[0]; r[2] = rd[4]; end
         2'd2: begin r[5] = rd[0]; r[1] = rd[4]; end
         default: begin r[4] = rd[0]; r[0] = rd[4]; end
      endcase
      return r;
   endfunction

   function automatic logic [7:0] disp_cmd(input logic en, input logic [2:0] lvl);
      return {CMD_DISP_ON[7:4], en, lvl};
   endfunction

endpackage

// File: rtl/tm1638_sequencer.sv
// Frame sequencer for a TM1638 display/key driver; talks to an external byte
// engine through a latch/busy handshake and owns the chip-select pin.
//
// state     | meaning
// IDLE      | waiting for a frame request
// KEY_CMD   | sending 0x42 (key scan)
// KEY_RD    | reading the 4 key-scan bytes
// WR_CMD    | sending 0x40 (auto-increment write)
// ADDR_CMD  | sending 0xC0 (start address)
// DATA      | sending 16 digit/LED bytes
// DISP_CMD  | sending display control
// GAP       | chip select held high between transactions
// FRAME_END | frame_done pulse, back to IDLE
module tm1638_sequencer
   import tm1638_pkg::*;
#(
   parameter int TICK_DIV = 20,
   parameter int CS_GAP   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] seg_data,
   input  logic [7:0]  led_data,
   input  logic [2:0]  bright,
   input  logic        disp_en,
   output logic        tm_cs,
   output logic        eng_latch,
   output logic        eng_rw,
   output logic [7:0]  eng_wdata,
   input  logic [7:0]  eng_rdata,
   input  logic        eng_busy,
   output logic [7:0]  keys,
   output logic        keys_valid,
   output logic        frame_done
);

   localparam logic [7:0] GAP_LOAD = (CS_GAP > 0) ? 8'(CS_GAP - 1) : 8'd0;

   logic [TICK_DIV-1:0] r_tick_cnt;
   logic                r_req;
   tm_state_e           r_state;
   tm_state_e           r_after_gap;
   byte_phase_e         r_phase;
   logic [3:0]          r_idx;
   logic [7:0]          r_gap_cnt;
   logic [63:0]         r_seg;
   logic [7:0]          r_led;
   logic [2:0]          r_bright;
   logic                r_en;
   logic [7:0]          r_key_acc;

   logic                w_tick_wrap;
   logic [7:0]          w_data_byte;
   logic [7:0]          w_tx_byte;
   logic [7:0]          w_key_next;

   assign w_tick_wrap = &r_tick_cnt;
   assign w_key_next  = key_merge(r_key_acc, r_idx[1:0], eng_rdata);

   // Even data slots carry a digit, odd slots the matching LED bit.
   assign w_data_byte = r_idx[0] ? {7'b0, r_led[r_idx[3:1]]}
                                 : r_seg[{r_idx[3:1], 3'b000} +: 8];

   always_comb begin
      w_tx_byte = 8'h00;
      case (r_state)
         KEY_CMD:  w_tx_byte = CMD_KEY_READ;
         WR_CMD:   w_tx_byte = CMD_WRITE_AUTO;
         ADDR_CMD: w_tx_byte = CMD_ADDR_0;
         DATA:     w_tx_byte = w_data_byte;
         DISP_CMD: w_tx_byte = disp_cmd(r_en, r_bright);
         default:  w_tx_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   // One-deep request: any number of wraps during a frame collapse into one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req <= 1'b0;
      end else if (w_tick_wrap) begin
         r_req <= 1'b1;
      end else if (r_state == IDLE) begin
         r_req <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_after_gap <= IDLE;
         r_phase     <= PH_ISSUE;
         r_idx       <= '0;
         r_gap_cnt   <= '0;
         r_seg       <= '0;
         r_led       <= '0;
         r_bright    <= '0;
         r_en        <= 1'b0;
         r_key_acc   <= '0;
         tm_cs       <= 1'b1;
         eng_latch   <= 1'b0;
         eng_rw      <= 1'b1;
         eng_wdata   <= 8'h00;
         keys        <= 8'h00;
         keys_valid  <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         eng_latch  <= 1'b0;
         keys_valid <= 1'b0;
         frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_req) begin
                  r_seg    <= seg_data;
                  r_led    <= led_data;
                  r_bright <= bright;
                  r_en     <= disp_en;
                  tm_cs    <= 1'b0;
                  r_phase  <= PH_ISSUE;
                  r_state  <= KEY_CMD;
               end
            end
            KEY_CMD, KEY_RD, WR_CMD, ADDR_CMD, DATA, DISP_CMD: begin
               case (r_phase)
                  PH_ISSUE: begin
                     if (!eng_busy) begin
                        eng_latch <= 1'b1;
                        eng_wdata <= w_tx_byte;
                        eng_rw    <= (r_state != KEY_RD);
                        r_phase   <= PH_WAIT_HI;
                     end
                  end
                  PH_WAIT_HI: begin
                     if (eng_busy) begin
                        r_phase <= PH_WAIT_LO;
                     end
                  end
                  PH_WAIT_LO: begin
                     if (!eng_busy) begin
                        r_phase <= PH_ISSUE;
                        case (r_state)
                           KEY_CMD: begin
                              r_idx   <= '0;
                              r_state <= KEY_RD;
                           end
                           KEY_RD: begin
                              r_key_acc <= w_key_next;
                              if (r_idx == 4'(N_KEY_BYTES - 1)) begin
                                 keys        <= w_key_next;
                                 keys_valid  <= 1'b1;
                                 tm_cs       <= 1'b1;
                                 r_gap_cnt   <= GAP_LOAD;
                                 r_after_gap <= WR_CMD;
                                 r_state     <= GAP;
                              end else begin
                                 r_idx <= r_idx + 4'd1;
                              end
                           end
                           WR_CMD: begin
                              tm_cs       <= 1'b1;
                              r_gap_cnt   <= GAP_LOAD;
                              r_after_gap <= ADDR_CMD;
                              r_state     <= GAP;
                           end
                           ADDR_CMD: begin
                              r_idx   <= '0;
                              r_state <= DATA;
                           end
                           DATA: begin
                              if (r_idx == 4'(N_DATA_BYTES - 1)) begin
                                 tm_cs       <= 1'b1;
                                 r_gap_cnt   <= GAP_LOAD;
                                 r_after_gap <= DISP_CMD;
                                 r_state     <= GAP;
                              end else begin
                                 r_idx <= r_idx + 4'd1;
                              end
                           end
                           default: begin
                              tm_cs       <= 1'b1;
                              r_gap_cnt   <= GAP_LOAD;
                              r_after_gap <= FRAME_END;
                              r_state     <= GAP;
                           end
                        endcase
                     end
                  end
                  default: r_phase <= PH_ISSUE;
               endcase
            end
            GAP: begin
               if (r_gap_cnt == 8'd0) begin
                  r_state <= r_after_gap;
                  if (r_after_gap == FRAME_END) begin
                     frame_done <= 1'b1;
                  end else begin
                     tm_cs <= 1'b0;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt - 8'd1;
               end
            end
            FRAME_END: r_state <= IDLE;
            default:   r_state <= IDLE;
         endcase
      end
   end

endmodule
